// File: rtl/point_ingress.sv
// Byte-stream front end for the weighted-centroid tracker: assembles {X,Y,W} triplets,
// drops zero weights, buffers points and issues them with a fixed idle gap between issues.
module point_ingress #(
  parameter int DEPTH = 4,
  parameter int GAP   = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [7:0] DIN,
  input  logic       DIN_VALID,
  output logic       DIN_READY,
  output logic [7:0] X,
  output logic [7:0] Y,
  output logic [3:0] W,
  output logic       DROP,
  output logic [2:0] POINTS,
  output logic       FULL6
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {S_X, S_Y, S_W} state_t;

  state_t          state_q, state_d;
  logic [7:0]      xl_q, xl_d;
  logic [7:0]      yl_q, yl_d;
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [7:0]      x_q, x_d;
  logic [7:0]      y_q, y_d;
  logic [3:0]      w_q, w_d;
  logic            drop_q, drop_d;
  logic [2:0]      points_q, points_d;
  logic [19:0]     mem_q [DEPTH];

  logic din_ready;
  logic accept;
  logic push;
  logic pop;

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_d  = state_q;
    xl_d     = xl_q;
    yl_d     = yl_q;
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    gcnt_d   = gcnt_q;
    x_d      = x_q;
    y_d      = y_q;
    w_d      = 4'd0;
    drop_d   = 1'b0;
    points_d = points_q;
    push     = 1'b0;

    // Ready looks only at the registered count, so a same-cycle pop never frees a slot.
    din_ready = (state_q != S_W) || (count_q != CW'(DEPTH));
    accept    = DIN_VALID && din_ready;

    if (accept) begin
      case (state_q)
        S_X: begin
          xl_d    = DIN;
          state_d = S_Y;
        end
        S_Y: begin
          yl_d    = DIN;
          state_d = S_W;
        end
        S_W: begin
          state_d = S_X;
          if (DIN[3:0] != 4'd0) push   = 1'b1;
          else                  drop_d = 1'b1;
        end
        default: state_d = S_X;
      endcase
    end

    pop = (count_q != '0) && (gcnt_q == '0);

    if (push) wptr_d = wptr_q + PW'(1);

    if (pop) begin
      rptr_d        = rptr_q + PW'(1);
      {x_d, y_d, w_d} = mem_q[rptr_q];
      gcnt_d        = GW'(GAP);
      points_d      = (points_q == 3'd6) ? points_q : points_q + 3'd1;
    end else if (gcnt_q != '0) begin
      gcnt_d = gcnt_q - GW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q  <= S_X;
      xl_q     <= 8'd0;
      yl_q     <= 8'd0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      gcnt_q   <= '0;
      x_q      <= 8'd0;
      y_q      <= 8'd0;
      w_q      <= 4'd0;
      drop_q   <= 1'b0;
      points_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      xl_q     <= xl_d;
      yl_q     <= yl_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      gcnt_q   <= gcnt_d;
      x_q      <= x_d;
      y_q      <= y_d;
      w_q      <= w_d;
      drop_q   <= drop_d;
      points_q <= points_d;
    end
  end

  // NOTE: storage is not reset; clearing the pointers and count already empties the FIFO.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wptr_q] <= {xl_q, yl_q, DIN[3:0]};
  end

  assign DIN_READY = din_ready;
  assign X         = x_q;
  assign Y         = y_q;
  assign W         = w_q;
  assign DROP      = drop_q;
  assign POINTS    = points_q;
  assign FULL6     = (points_q == 3'd6);

endmodule

// File: tb/tb_point_ingress.sv
// Directed bench for point_ingress: scoreboard of expected issued points, checked by a
// monitor sampling 1 time unit after each rising edge.
module tb_point_ingress;

  localparam int DEPTH = 4;
  localparam int GAP   = 7;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic [7:0] DIN = 8'd0;
  logic       DIN_VALID = 1'b0;
  logic       DIN_READY;
  logic [7:0] X;
  logic [7:0] Y;
  logic [3:0] W;
  logic       DROP;
  logic [2:0] POINTS;
  logic       FULL6;

  point_ingress #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .DIN       (DIN),
    .DIN_VALID (DIN_VALID),
    .DIN_READY (DIN_READY),
    .X         (X),
    .Y         (Y),
    .W         (W),
    .DROP      (DROP),
    .POINTS    (POINTS),
    .FULL6     (FULL6)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          errors = 0;
  logic [19:0] sb[$];
  int          pulse_cyc[$];
  int          cyc = 0;
  int          pts_model = 0;
  int          drops_seen = 0;
  bit          stall_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue monitor: every W pulse must match the head of the scoreboard.
  initial begin
    logic [19:0] exp;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (RESET) begin
        if (W != 4'd0) begin
          check("issue_expected", 32'(sb.size() != 0), 32'd1);
          if (sb.size() != 0) begin
            exp = sb.pop_front();
            check("issue_xyw", {12'd0, X, Y, W}, {12'd0, exp});
          end
          pts_model = (pts_model == 6) ? 6 : pts_model + 1;
          check("points", {29'd0, POINTS}, 32'(pts_model));
          check("full6", {31'd0, FULL6}, 32'(pts_model == 6));
          pulse_cyc.push_back(cyc);
        end
        if (DROP) drops_seen++;
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int budget;
    @(negedge CLK);
    DIN       = b;
    DIN_VALID = 1'b1;
    budget    = 0;
    while (!DIN_READY && budget < 200) begin
      stall_seen = 1'b1;
      @(negedge CLK);
      budget++;
    end
    if (!DIN_READY) check("din_ready_timeout", {31'd0, DIN_READY}, 32'd1);
    @(posedge CLK);
  endtask

  task automatic triplet(input logic [7:0] x, input logic [7:0] y, input logic [7:0] w);
    send(x);
    send(y);
    send(w);
    if (w[3:0] != 4'd0) sb.push_back({x, y, w[3:0]});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge CLK);
      DIN_VALID = 1'b0;
      @(posedge CLK);
    end
  endtask

  task automatic check_reset_state(input string p);
    check({p, "_x"},      {24'd0, X},      32'd0);
    check({p, "_y"},      {24'd0, Y},      32'd0);
    check({p, "_w"},      {28'd0, W},      32'd0);
    check({p, "_drop"},   {31'd0, DROP},   32'd0);
    check({p, "_points"}, {29'd0, POINTS}, 32'd0);
    check({p, "_full6"},  {31'd0, FULL6},  32'd0);
    check({p, "_ready"},  {31'd0, DIN_READY}, 32'd1);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET     = 1'b0;
    DIN_VALID = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    sb.delete();
    pts_model = 0;
    RESET     = 1'b1;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int budget;

    // Power-on reset.
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b1;
    #1;
    check_reset_state("init");

    // Single point: pulse exactly one cycle, two edges after the W byte.
    triplet(8'h10, 8'h20, 8'h05);
    @(negedge CLK);
    DIN_VALID = 1'b0;
    check("sp_w_before", {28'd0, W}, 32'd0);
    @(posedge CLK);
    #1;
    check("sp_x", {24'd0, X}, 32'h10);
    check("sp_y", {24'd0, Y}, 32'h20);
    check("sp_w", {28'd0, W}, 32'd5);
    @(posedge CLK);
    #1;
    check("sp_w_after", {28'd0, W}, 32'd0);
    idle(10);
    check("sp_points", {29'd0, POINTS}, 32'd1);

    // Zero weight: one DROP pulse, no issue, next byte is X again.
    triplet(8'h33, 8'h44, 8'hF0);
    @(negedge CLK);
    DIN_VALID = 1'b0;
    check("zw_drop_hi", {31'd0, DROP}, 32'd1);
    @(negedge CLK);
    check("zw_drop_lo", {31'd0, DROP}, 32'd0);
    check("zw_points", {29'd0, POINTS}, 32'd1);
    triplet(8'h55, 8'h66, 8'h07);
    idle(12);
    check("zw_drops_seen", 32'(drops_seen), 32'd1);
    check("zw_sb_empty", 32'(sb.size()), 32'd0);
    check("zw_points_after", {29'd0, POINTS}, 32'd2);

    // Reset mid-triplet with a point still queued: queue and partial triplet discarded.
    triplet(8'hA1, 8'hA2, 8'h03);
    triplet(8'hB1, 8'hB2, 8'h04);
    send(8'hC0);
    do_reset();
    check_reset_state("mid");
    triplet(8'h01, 8'h02, 8'h03);
    idle(12);
    check("mid_sb_empty", 32'(sb.size()), 32'd0);
    check("mid_points", {29'd0, POINTS}, 32'd1);

    // Backpressure, push+pop at DEPTH-1, pointer wrap and POINTS saturation.
    do_reset();
    pulse_cyc.delete();
    stall_seen = 1'b0;
    for (int i = 0; i < 5; i++) triplet(8'h20 + 8'(i), 8'h40 + 8'(i), 8'(i + 1));
    idle(2);
    for (int i = 5; i < 8; i++) triplet(8'h20 + 8'(i), 8'h40 + 8'(i), 8'(i + 1));
    idle(1);
    budget = 0;
    while (sb.size() != 0 && budget < 200) begin
      @(posedge CLK);
      budget++;
    end
    idle(2);
    check("bp_drained", 32'(sb.size()), 32'd0);
    check("bp_stall_seen", {31'd0, stall_seen}, 32'd1);
    check("bp_pulses", 32'(pulse_cyc.size()), 32'd8);
    if (pulse_cyc.size() == 8) begin
      for (int i = 1; i < 8; i++)
        check("bp_spacing", 32'(pulse_cyc[i] - pulse_cyc[i-1]), 32'(GAP + 1));
    end
    check("bp_points", {29'd0, POINTS}, 32'd6);
    check("bp_full6", {31'd0, FULL6}, 32'd1);
    check("bp_ready", {31'd0, DIN_READY}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
